// File: rtl/data_mem_if.sv
// Load/store request bus between the memory stage (master) and the data memory (slave).
interface data_mem_if;
  logic        data_mem_req_i;
  logic [63:0] data_mem_addr_i;
  logic [2:0]  data_mem_row_idx_i;
  logic [1:0]  data_byte_en_i;
  logic        data_mem_wr_i;
  logic [63:0] data_mem_wr_data_i;
  logic        data_mem_ready_o;
  logic [63:0] mem_rd_data_o;
  logic        mem_rd_valid_o;
  logic        init_done_o;

  modport master (
    output data_mem_req_i, data_mem_addr_i, data_mem_row_idx_i,
           data_byte_en_i, data_mem_wr_i, data_mem_wr_data_i,
    input  data_mem_ready_o, mem_rd_data_o, mem_rd_valid_o, init_done_o
  );

  modport slave (
    input  data_mem_req_i, data_mem_addr_i, data_mem_row_idx_i,
           data_byte_en_i, data_mem_wr_i, data_mem_wr_data_i,
    output data_mem_ready_o, mem_rd_data_o, mem_rd_valid_o, init_done_o
  );
endinterface

// File: rtl/data_mem.sv
// Row-organised data memory: zero-fills itself after reset, merges stores into byte
// lanes of a 64-bit row and returns the raw row for loads after a one-cycle pipeline.
module data_mem #(
  parameter int MEM_SIZE = 524288,
  parameter int DEPTH    = MEM_SIZE / 8,
  parameter int IDX_W    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  data_mem_if.slave  bus
);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [63:0]      mem_q [DEPTH];

  logic             ready_s, init_done_s;
  logic             accept_s, load_s, store_s, cross_s;
  logic [IDX_W-1:0] row_s, wr_idx_s;
  logic [7:0]       strb_s;
  logic [63:0]      row_rd_s, shifted_s, merged_s, wr_row_s;
  logic             wr_en_s;
  logic             unused_addr_s;

  logic             pend_q, pend_d;
  logic [63:0]      pend_data_q, pend_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic [63:0]      rd_data_q, rd_data_d;

  function automatic logic [7:0] byte_strobe(input logic [2:0] idx, input logic [1:0] size);
    logic [15:0] mask;
    case (size)
      2'b00:   mask = 16'h0001;
      2'b01:   mask = 16'h0003;
      2'b10:   mask = 16'h000F;
      2'b11:   mask = 16'h00FF;
      default: mask = 16'h0001;
    endcase
    mask = mask << idx;
    return mask[7:0];
  endfunction

  function automatic logic is_crossing(input logic [2:0] idx, input logic [1:0] size);
    logic [3:0] last;
    last = {1'b0, idx} + (4'd1 << size);
    return (last > 4'd8);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_INIT;
    endcase
  end

  always_comb begin
    ready_s     = 1'b0;
    init_done_s = 1'b0;
    case (state_q)
      ST_READY: begin
        ready_s     = 1'b1;
        init_done_s = 1'b1;
      end
      default: begin
        ready_s     = 1'b0;
        init_done_s = 1'b0;
      end
    endcase
  end

  // Request decode and byte-lane merge against the current contents of the row.
  always_comb begin
    row_s     = bus.data_mem_addr_i[IDX_W+2:3];
    accept_s  = bus.data_mem_req_i & ready_s;
    load_s    = accept_s & ~bus.data_mem_wr_i;
    strb_s    = byte_strobe(bus.data_mem_row_idx_i, bus.data_byte_en_i);
    cross_s   = is_crossing(bus.data_mem_row_idx_i, bus.data_byte_en_i);
    store_s   = accept_s & bus.data_mem_wr_i & ~cross_s;
    row_rd_s  = mem_q[row_s];
    shifted_s = bus.data_mem_wr_data_i << {bus.data_mem_row_idx_i, 3'b000};
    merged_s  = row_rd_s;
    for (int b = 0; b < 8; b++) begin
      if (strb_s[b]) begin
        merged_s[8*b +: 8] = shifted_s[8*b +: 8];
      end else begin
        merged_s[8*b +: 8] = row_rd_s[8*b +: 8];
      end
    end
  end

  // During INIT the zero-fill owns the write port; requests are not accepted then.
  always_comb begin
    wr_en_s  = 1'b0;
    wr_idx_s = row_s;
    wr_row_s = merged_s;
    if (state_q == ST_INIT) begin
      wr_en_s  = 1'b1;
      wr_idx_s = cnt_q;
      wr_row_s = 64'h0;
    end else begin
      wr_en_s  = store_s;
      wr_idx_s = row_s;
      wr_row_s = merged_s;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_idx_s] <= wr_row_s;
    end
  end

  always_comb begin
    pend_d      = load_s;
    pend_data_d = pend_data_q;
    rd_valid_d  = pend_q;
    rd_data_d   = rd_data_q;
    if (load_s) begin
      pend_data_d = row_rd_s;
    end else begin
      pend_data_d = pend_data_q;
    end
    if (pend_q) begin
      rd_data_d = pend_data_q;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  // Two-stage read response; reset drops anything still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_data_q <= 64'h0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= 64'h0;
    end else begin
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign unused_addr_s        = ^{bus.data_mem_addr_i[63:IDX_W+3], bus.data_mem_addr_i[2:0]};
  assign bus.data_mem_ready_o = ready_s;
  assign bus.init_done_o      = init_done_s;
  assign bus.mem_rd_valid_o   = rd_valid_q;
  assign bus.mem_rd_data_o    = rd_data_q;

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem with an 8-row array.
module tb_data_mem;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  data_mem_if bus ();

  data_mem #(.MEM_SIZE(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic req, input logic wr, input logic [63:0] addr,
                         input logic [2:0] idx, input logic [1:0] sz, input logic [63:0] wd);
    bus.data_mem_req_i     = req;
    bus.data_mem_wr_i      = wr;
    bus.data_mem_addr_i    = addr;
    bus.data_mem_row_idx_i = idx;
    bus.data_byte_en_i     = sz;
    bus.data_mem_wr_data_i = wd;
  endtask

  task automatic store_row(input logic [63:0] addr, input logic [2:0] idx, input logic [1:0] sz,
                           input logic [63:0] wd, output logic v);
    set_req(1'b1, 1'b1, addr, idx, sz, wd);
    tick();
    v = bus.mem_rd_valid_o;
    set_req(1'b0, 1'b0, 64'h0, 3'd0, 2'd0, 64'h0);
  endtask

  task automatic load_row(input logic [63:0] addr, input logic [2:0] idx, input logic [1:0] sz,
                          output logic v0, output logic v, output logic [63:0] d);
    set_req(1'b1, 1'b0, addr, idx, sz, 64'h0);
    tick();
    v0 = bus.mem_rd_valid_o;
    set_req(1'b0, 1'b0, 64'h0, 3'd0, 2'd0, 64'h0);
    tick();
    v = bus.mem_rd_valid_o;
    d = bus.mem_rd_data_o;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.data_mem_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", bus.data_mem_ready_o); end
    checks++; if (bus.init_done_o !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b exp 0", bus.init_done_o); end
    checks++; if (bus.mem_rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.mem_rd_valid_o); end
    checks++; if (bus.mem_rd_data_o !== 64'h0) begin errors++; $display("FAIL reset_data got %h exp 0", bus.mem_rd_data_o); end
  endtask

  task automatic test_init();
    logic exp;
    set_req(1'b1, 1'b0, 64'h10, 3'd0, 2'd3, 64'h0);
    tick();
    rst_n = 1'b1;
    checks++; if (bus.data_mem_ready_o !== 1'b0) begin errors++; $display("FAIL init_ready_pre got %b exp 0", bus.data_mem_ready_o); end
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = (i == 8);
      checks++; if (bus.data_mem_ready_o !== exp) begin errors++; $display("FAIL init_ready cyc %0d got %b exp %b", i, bus.data_mem_ready_o, exp); end
      checks++; if (bus.init_done_o !== exp) begin errors++; $display("FAIL init_done cyc %0d got %b exp %b", i, bus.init_done_o, exp); end
      checks++; if (bus.mem_rd_valid_o !== 1'b0) begin errors++; $display("FAIL init_valid cyc %0d got %b exp 0", i, bus.mem_rd_valid_o); end
    end
    tick();
    set_req(1'b0, 1'b0, 64'h0, 3'd0, 2'd0, 64'h0);
    checks++; if (bus.mem_rd_valid_o !== 1'b0) begin errors++; $display("FAIL init_load_early got %b exp 0", bus.mem_rd_valid_o); end
    tick();
    checks++; if (bus.mem_rd_valid_o !== 1'b1) begin errors++; $display("FAIL init_load_valid got %b exp 1", bus.mem_rd_valid_o); end
    checks++; if (bus.mem_rd_data_o !== 64'h0) begin errors++; $display("FAIL init_load_data got %h exp 0", bus.mem_rd_data_o); end
    tick();
    checks++; if (bus.mem_rd_valid_o !== 1'b0) begin errors++; $display("FAIL init_load_single got %b exp 0", bus.mem_rd_valid_o); end
  endtask

  task automatic test_dw_store_load();
    logic v0, v, vs;
    logic [63:0] d;
    store_row(64'h18, 3'd0, 2'd3, 64'h0123456789ABCDEF, vs);
    load_row(64'h18, 3'd0, 2'd3, v0, v, d);
    checks++; if (vs !== 1'b0) begin errors++; $display("FAIL dw_store_valid got %b exp 0", vs); end
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL dw_load_early got %b exp 0", v0); end
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL dw_load_valid got %b exp 1", v); end
    checks++; if (d !== 64'h0123456789ABCDEF) begin errors++; $display("FAIL dw_load_data got %h exp 0123456789abcdef", d); end
  endtask

  task automatic test_byte_merge();
    logic v0, v, vs;
    logic [63:0] d;
    store_row(64'h18, 3'd5, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB, vs);
    load_row(64'h18, 3'd0, 2'd3, v0, v, d);
    checks++; if (vs !== 1'b0) begin errors++; $display("FAIL byte_store_valid got %b exp 0", vs); end
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL byte_load_valid got %b exp 1", v); end
    checks++; if (d !== 64'h0123AB6789ABCDEF) begin errors++; $display("FAIL byte_merge_data got %h exp 0123ab6789abcdef", d); end
  endtask

  task automatic test_crossing_store();
    logic v0, v, vs;
    logic [63:0] d;
    store_row(64'h18, 3'd7, 2'd1, 64'h5555, vs);
    tick();
    load_row(64'h18, 3'd7, 2'd1, v0, v, d);
    checks++; if (vs !== 1'b0) begin errors++; $display("FAIL cross_store_valid got %b exp 0", vs); end
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL cross_load_valid got %b exp 1", v); end
    checks++; if (d !== 64'h0123AB6789ABCDEF) begin errors++; $display("FAIL cross_store_data got %h exp 0123ab6789abcdef", d); end
  endtask

  task automatic test_word_upper();
    logic v0, v, vs;
    logic [63:0] d;
    store_row(64'h20, 3'd4, 2'd2, 64'h0000_0000_DEAD_BEEF, vs);
    load_row(64'h20, 3'd0, 2'd3, v0, v, d);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL word_load_valid got %b exp 1", v); end
    checks++; if (d !== 64'hDEADBEEF00000000) begin errors++; $display("FAIL word_upper_data got %h exp deadbeef00000000", d); end
  endtask

  task automatic test_back_to_back();
    set_req(1'b1, 1'b0, 64'h18, 3'd0, 2'd3, 64'h0);
    tick();
    set_req(1'b1, 1'b0, 64'h20, 3'd0, 2'd3, 64'h0);
    tick();
    set_req(1'b0, 1'b0, 64'h0, 3'd0, 2'd0, 64'h0);
    checks++; if (bus.mem_rd_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid0 got %b exp 1", bus.mem_rd_valid_o); end
    checks++; if (bus.mem_rd_data_o !== 64'h0123AB6789ABCDEF) begin errors++; $display("FAIL b2b_data0 got %h exp 0123ab6789abcdef", bus.mem_rd_data_o); end
    tick();
    checks++; if (bus.mem_rd_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid1 got %b exp 1", bus.mem_rd_valid_o); end
    checks++; if (bus.mem_rd_data_o !== 64'hDEADBEEF00000000) begin errors++; $display("FAIL b2b_data1 got %h exp deadbeef00000000", bus.mem_rd_data_o); end
    tick();
    checks++; if (bus.mem_rd_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", bus.mem_rd_valid_o); end
    checks++; if (bus.mem_rd_data_o !== 64'hDEADBEEF00000000) begin errors++; $display("FAIL b2b_hold got %h exp deadbeef00000000", bus.mem_rd_data_o); end
  endtask

  task automatic test_reset_mid();
    logic v0, v, exp;
    logic [63:0] d;
    int pulses;
    pulses = 0;
    set_req(1'b1, 1'b0, 64'h20, 3'd0, 2'd3, 64'h0);
    tick();
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 64'h0, 3'd0, 2'd0, 64'h0);
    #1;
    checks++; if (bus.data_mem_ready_o !== 1'b0) begin errors++; $display("FAIL rmid_ready got %b exp 0", bus.data_mem_ready_o); end
    checks++; if (bus.init_done_o !== 1'b0) begin errors++; $display("FAIL rmid_init_done got %b exp 0", bus.init_done_o); end
    checks++; if (bus.mem_rd_data_o !== 64'h0) begin errors++; $display("FAIL rmid_data got %h exp 0", bus.mem_rd_data_o); end
    if (bus.mem_rd_valid_o !== 1'b0) pulses++;
    tick();
    if (bus.mem_rd_valid_o !== 1'b0) pulses++;
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = (i == 8);
      if (bus.mem_rd_valid_o !== 1'b0) pulses++;
      checks++; if (bus.data_mem_ready_o !== exp) begin errors++; $display("FAIL rmid_ready cyc %0d got %b exp %b", i, bus.data_mem_ready_o, exp); end
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rmid_no_pulse got %0d pulses exp 0", pulses); end
    load_row(64'h18, 3'd0, 2'd3, v0, v, d);
    checks++; if (v !== 1'b1) begin errors++; $display("FAIL rmid_load_valid got %b exp 1", v); end
    checks++; if (d !== 64'h0) begin errors++; $display("FAIL rmid_refill_data got %h exp 0", d); end
  endtask

  initial begin
    rst_n = 1'b0;
    set_req(1'b0, 1'b0, 64'h0, 3'd0, 2'd0, 64'h0);
    test_reset();
    test_init();
    test_dw_store_load();
    test_byte_merge();
    test_crossing_store();
    test_word_upper();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem.md
# data_mem

Data-memory responder that services the load/store requests issued by the memory stage. It accepts 64-bit row-aligned requests carrying a byte index within the row and an access size. It merges store data into the addressed byte lanes of an on-chip row array and returns the raw 64-bit row for loads one cycle later. After every reset it zero-fills the whole array before it accepts any request. Byte extraction and sign extension for loads stay in writeback.

## Interface

Parameters:
- MEM_SIZE, default 524288: capacity in bytes; must be a power of two and a multiple of 8.
- DEPTH, default MEM_SIZE/8: number of 64-bit rows (derived).
- IDX_W, default $clog2(DEPTH): row index width (derived).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_mem_req_i  input  1  request valid.
- data_mem_addr_i  input  64  row-aligned byte address.
  - Bits [2:0] are ignored.
  - Row index is bits [IDX_W+2:3]; upper bits are ignored (the memory stage already rejects out-of-range addresses).
- data_mem_row_idx_i  input  3  first byte of the access within the row.
- data_byte_en_i  input  2  access size: BYTE=2'b00, HALF_WORD=2'b01, WORD=2'b10, DOUBLE_WORD=2'b11.
- data_mem_wr_i  input  1  1 = store, 0 = load.
- data_mem_wr_data_i  input  64  store data, right-justified (the value sits in the low bytes).
- data_mem_ready_o  output  1  responder can accept a request this cycle.
- mem_rd_data_o  output  64  raw row for the last accepted load.
- mem_rd_valid_o  output  1  one-cycle pulse; mem_rd_data_o is valid.
- init_done_o  output  1  zero-fill complete; stays 1 until the next reset.

## Operation

- State machine:
  - INIT
    - A row counter cnt (IDX_W bits) writes 64'h0 to row cnt each cycle and increments.
    - data_mem_ready_o is 0; requests are ignored, and the initiator holds them.
    - When cnt == DEPTH-1, the final zero row is written and the state moves to READY on the same edge.
  - READY
    - Terminal state until reset; data_mem_ready_o = 1 and init_done_o = 1.
    - Accept condition: data_mem_req_i & data_mem_ready_o.
- Byte count: n = 1 << data_byte_en_i (1, 2, 4 or 8).
- Byte strobe: strb[7:0] = ((1<<n)-1) << data_mem_row_idx_i.
- Crossing rule: an access is a crossing access if data_mem_row_idx_i + n > 8.
  - A crossing store is dropped with no array change.
  - A crossing load is still performed and returns the row.
- Accepted store:
  - Shifted data = data_mem_wr_data_i << (8*data_mem_row_idx_i).
  - For each byte b with strb[b] = 1, row byte b takes byte b of the shifted data.
  - All other bytes are unchanged.
  - No read response is produced (mem_rd_valid_o stays 0).
- Accepted load: the full row is registered to mem_rd_data_o and mem_rd_valid_o pulses on the next cycle.
- At most one request per cycle. A load on the cycle after a store to the same row returns the updated bytes.

## Timing

- Reset values: data_mem_ready_o = 0, mem_rd_valid_o = 0, mem_rd_data_o = 64'h0, init_done_o = 0, state = INIT, cnt = 0.
- Zero-fill: DEPTH cycles after rst_n deasserts. data_mem_ready_o rises at the edge that writes row DEPTH-1, so it is high DEPTH cycles after the first edge.
- Load latency: 1 cycle. A load accepted at edge N presents mem_rd_valid_o = 1 with its data after edge N+1.
- Back-to-back loads give consecutive valid pulses.
- mem_rd_data_o holds its last value while mem_rd_valid_o = 0.
- Store commit: at the accepting edge. It is visible to a load accepted at the following edge.
- Reset asserted mid-INIT or mid-READY:
  - All outputs return to their reset values immediately (asynchronous reset).
  - A pending read response is discarded.
  - The array is zero-filled again from row 0 after deassertion.
- A request held while data_mem_ready_o = 0 is accepted on the first cycle ready is 1.

## Test plan

- Init: MEM_SIZE=64 (DEPTH=8).
  - Release reset with data_mem_req_i = 1 (load, addr 0x10) held.
  - Required: data_mem_ready_o = 0 for 8 cycles, then 1; init_done_o rises on the same cycle.
  - Required: the held load returns 64'h0 with a single valid pulse.
- Double-word store then load:
  - Store 64'h0123456789ABCDEF to addr 0x18, idx 0, DOUBLE_WORD.
  - Load addr 0x18 on the next cycle.
  - Required: mem_rd_data_o = 64'h0123456789ABCDEF one cycle after load acceptance.
- Byte merge:
  - After the above, store 0xAB to addr 0x18, idx 5, BYTE, with data_mem_wr_data_i = 64'hFFFF_FFFF_FFFF_FFAB.
  - Required: a load returns 64'h0123AB6789ABCDEF.
- Crossing store:
  - Store HALF_WORD 0x5555 to addr 0x18, idx 7.
  - Required: the row is unchanged, and mem_rd_valid_o stays 0 during the store.
- Word store at upper half:
  - Store 0xDEADBEEF to addr 0x20, idx 4, WORD.
  - Required: a load returns 64'hDEADBEEF00000000.
- Reset mid-operation:
  - Assert rst_n = 0 on the cycle a load is accepted.
  - Required: mem_rd_valid_o never pulses, and ready returns after 8 cycles.
  - Required: a load of addr 0x18 then returns 64'h0.
